// File: rtl/ssp_pkg.sv
// ssp_pkg: shared constants and types for the superscalar store buffer.
// Opcode encodings, default widths and the store-buffer entry layout.
package ssp_pkg;

    localparam logic [5:0] OP_LW = 6'b010000;
    localparam logic [5:0] OP_SW = 6'b010001;

    localparam int SSP_AW = 10;
    localparam int SSP_DW = 32;

    typedef struct packed {
        logic              valid;
        logic [SSP_AW-1:0] addr;
        logic [SSP_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/ssp_sb_match.sv
// ssp_sb_match: youngest-match search over the live store-buffer window.
// Scans oldest to youngest so the last hit (youngest) wins.
module ssp_sb_match
    import ssp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SSP_AW,
    parameter int DW    = SSP_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic [AW-1:0]    addr,
    input  logic [PW-1:0]    head,
    input  logic [CW-1:0]    count,
    input  logic [DEPTH-1:0] ent_valid,
    input  logic [AW-1:0]    ent_addr [DEPTH],
    input  logic [DW-1:0]    ent_data [DEPTH],
    output logic             hit,
    output logic [DW-1:0]    data
);

    logic [PW-1:0] idx;

    // Walk head..tail-1; later (younger) matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && ent_valid[idx] &&
                (ent_addr[idx] == addr)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/ssp_store_buffer.sv
// ssp_store_buffer: dual-lane load/store unit with a FIFO store buffer.
// Stores drain one per cycle; loads forward from the pair or the buffer.
module ssp_store_buffer
    import ssp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SSP_AW,
    parameter int DW    = SSP_DW
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    input  logic [1:0]    req_we,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    output logic          req_ready,
    output logic [1:0]    ld_valid,
    output logic [DW-1:0] ld_data0,
    output logic [DW-1:0] ld_data1,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr0,
    output logic [AW-1:0] mem_raddr1,
    input  logic [DW-1:0] mem_rdata0,
    input  logic [DW-1:0] mem_rdata1,
    output logic          sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [1:0]       ld_valid_q, ld_valid_d;
    logic [DW-1:0]    ld_data0_q, ld_data0_d;
    logic [DW-1:0]    ld_data1_q, ld_data1_d;

    logic          st0, st1, ld0, ld1;
    logic          drain, fwd1;
    logic [PW-1:0] wr1_idx;
    logic          hit0, hit1;
    logic [DW-1:0] hdata0, hdata1;

    assign req_ready  = (count_q <= READY_MAX);
    assign drain      = (count_q != '0);
    assign sb_empty   = (count_q == '0);
    assign mem_we     = drain;
    assign mem_waddr  = addr_q[head_q];
    assign mem_wdata  = data_q[head_q];
    assign mem_raddr0 = req_addr0;
    assign mem_raddr1 = req_addr1;
    assign ld_valid   = ld_valid_q;
    assign ld_data0   = ld_data0_q;
    assign ld_data1   = ld_data1_q;

    ssp_sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match0 (
        .addr      (req_addr0),
        .head      (head_q),
        .count     (count_q),
        .ent_valid (valid_q),
        .ent_addr  (addr_q),
        .ent_data  (data_q),
        .hit       (hit0),
        .data      (hdata0)
    );

    ssp_sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match1 (
        .addr      (req_addr1),
        .head      (head_q),
        .count     (count_q),
        .ent_valid (valid_q),
        .ent_addr  (addr_q),
        .ent_data  (data_q),
        .hit       (hit1),
        .data      (hdata1)
    );

    // Per-lane accept decode; the pair is taken whole when ready.
    always_comb begin
        st0     = req_ready & req_valid[0] & req_we[0];
        st1     = req_ready & req_valid[1] & req_we[1];
        ld0     = req_ready & req_valid[0] & ~req_we[0];
        ld1     = req_ready & req_valid[1] & ~req_we[1];
        fwd1    = st0 & (req_addr0 == req_addr1);
        wr1_idx = st0 ? (tail_q + PW'(1)) : tail_q;
    end

    // Buffer update: retire head, then append lane 0 and lane 1 stores.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (drain) begin
            valid_d[head_q] = 1'b0;
        end
        if (st0) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = req_addr0;
            data_d[tail_q]  = req_wdata0;
        end
        if (st1) begin
            valid_d[wr1_idx] = 1'b1;
            addr_d[wr1_idx]  = req_addr1;
            data_d[wr1_idx]  = req_wdata1;
        end
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(st0) + PW'(st1);
        count_d = count_q + CW'(st0) + CW'(st1) - CW'(drain);
    end

    // Load results: pair forward beats buffer hit beats MEM.
    always_comb begin
        ld_valid_d = {ld1, ld0};
        ld_data0_d = ld_data0_q;
        ld_data1_d = ld_data1_q;
        if (ld0) begin
            ld_data0_d = hit0 ? hdata0 : mem_rdata0;
        end
        if (ld1) begin
            if (fwd1) begin
                ld_data1_d = req_wdata0;
            end else if (hit1) begin
                ld_data1_d = hdata1;
            end else begin
                ld_data1_d = mem_rdata1;
            end
        end
    end

    // State registers; reset empties the buffer and clears load outputs.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            ld_valid_q <= '0;
            ld_data0_q <= '0;
            ld_data1_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            ld_valid_q <= ld_valid_d;
            ld_data0_q <= ld_data0_d;
            ld_data1_q <= ld_data1_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule
